uart_line_capture: RTL
======================

# uart_line_capture

Synthesizable, parametrised UART line receiver that turns a serial `uart_rx` stream into a captured multi-byte line for on-chip checking or LCD display. It oversamples the line, frames bytes with start/stop validation, and shifts each byte into a DEPTH-byte window with the newest byte in the least-significant position. A line is complete after a configurable idle gap, and is then held for a valid/ack handshake. It sits beside the lab9 top level so the design can observe its own UART output without bench-only timing code.

## Interface
- `CLK_HZ`, 100_000_000: system clock frequency.
- `BAUD`, 9600: line rate; bit period `DIV = (CLK_HZ + BAUD/2) / BAUD` cycles (10417 at defaults).
- `DATA_BITS`, 8: data bits per frame, 5..9, sent LSB first.
- `DEPTH`, 30: bytes held in the line window.
- `IDLE_BITS`, 20: idle bit-times after the last stop bit that end a line.

- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `uart_rx`  in  1  asynchronous serial input, idle high.
- `line_ack`  in  1  consumer accepts the held line.
- `byte_valid`  out  1  one-cycle pulse per accepted byte.
- `byte_data`  out  DATA_BITS  last accepted byte.
- `line`  out  DEPTH*DATA_BITS  window; newest byte in `[DATA_BITS-1:0]`.
- `line_count`  out  $clog2(DEPTH+1)  bytes in the window, saturating at DEPTH.
- `line_valid`  out  1  line complete and held.
- `line_trunc`  out  1  more than DEPTH bytes arrived in this line.
- `frame_err`  out  1  sticky: a stop bit was sampled low.
- `overrun`  out  1  sticky: a byte arrived while `line_valid` was high.
- `parity_err`  out  1  sticky; present only with the configuration macro.

## Operation
- Synchroniser: `uart_rx` passes through two flops, each reset to 1. All decisions use the synchronised value.
- FSM states are IDLE, START, DATA, (PARITY), STOP.
  - IDLE: a falling edge moves to START and clears the bit timer.
  - START: at `DIV/2` cycles, the line is re-sampled. If it is high, this is a false start and the FSM returns to IDLE with no flags. If it is low, the FSM goes to DATA.
  - DATA: DATA_BITS samples, one every DIV cycles at bit centre, shifted in LSB first.
  - STOP: one sample at bit centre. If high, the byte is accepted. If low, `frame_err` is set, the byte is dropped, and the FSM waits in IDLE for the line to return high before detecting a new start.
- Accept, with `line_valid` low:
  - window ← `{window[(DEPTH-1)*DATA_BITS-1:0], byte}`; the oldest byte falls off.
  - `line_count` ← min(`line_count`+1, DEPTH).
  - If `line_count` was already DEPTH, `line_trunc` is set.
  - The idle counter is cleared.
- Accept, with `line_valid` high: the byte is not stored, `overrun` is set, and `byte_valid` still pulses.
- Line end: the idle counter counts cycles while the FSM is in IDLE and `line_count`≠0. When it reaches `IDLE_BITS*DIV`, `line_valid` ← 1.
- Ack: when `line_valid` and `line_ack` are both high, `line_valid`, `line_count`, `line_trunc`, and the window are cleared on the next edge. `line_ack` while `line_valid` is low is ignored.
- The sticky flags `frame_err`, `overrun`, and `parity_err` clear only on reset.

## Timing
- Reset: all outputs are 0 and the window is 0. The FSM is IDLE, the synchroniser reads 1, and the counters are 0. Reset mid-frame abandons the frame; no partial byte is stored.
- The sample point is centre of bit ±1 cycle, measured from the synchronised falling edge. The synchroniser adds 2 cycles of latency.
- `byte_valid` pulses, and `byte_data`, `line`, and `line_count` update, on the cycle after the stop-bit sample.
- `line_valid` rises exactly `IDLE_BITS*DIV` cycles after the stop-bit sample of the last byte.
- A start edge during the idle count resets the count; that line is not completed.
- If an ack and a stop-bit accept occur in the same cycle, the ack wins: the line clears, the byte is dropped, and `overrun` is set.

## Configuration
- `UART_CAPTURE_PARITY_EN`: with the macro defined, one even-parity bit is expected between DATA and STOP. A mismatch sets `parity_err` and drops the byte; the frame still completes through STOP.
- Without the macro, there is no PARITY state and no `parity_err` port, and the frame is start + DATA_BITS + stop.

## Test plan
- Defaults; send "OK" (0x4F, 0x4B) at 9600 baud → two `byte_valid` pulses. `line_count`=2 and `line[15:0]`=16'h4F4B; `line_valid` rises 208340 cycles after the last stop sample.
- Low glitch of 3000 cycles on `uart_rx` → no `byte_valid`, no flags, FSM back in IDLE.
- Frame 0x55 with stop bit driven low → `frame_err`=1, `line_count` stays 0; the next good byte 0x41 is stored normally.
- 31 bytes 0x01..0x1F back-to-back, then idle → `line_count`=30, `line_trunc`=1, `line[7:0]`=0x1F, `line[239:232]`=0x02.
- With `line_valid` held, send 0x33 → `byte_valid` pulses and `overrun`=1, while `line` is unchanged. Pulse `line_ack` → `line_valid`=0, `line_count`=0.
- Assert `reset` for one cycle mid-data-bit of 0x5A, then send 0x5A again → exactly one byte 0x5A is captured.

Source files
------------

// File: rtl/uart_line_capture_if.sv
// uart_line_capture_if: serial input, line handshake and status bundle.
// Members:
//   uart_rx     serial input, idle high
//   line_ack    consumer accepts the held line
//   byte_valid  one-cycle pulse per accepted byte
//   byte_data   last accepted byte
//   line        byte window, newest byte in the low bits
//   line_count  bytes in the window, saturating at DEPTH
//   line_valid  line complete and held until acked
//   line_trunc  more than DEPTH bytes arrived in this line
//   frame_err   sticky: a stop bit was sampled low
//   overrun     sticky: a byte arrived while line_valid was high
//   parity_err  sticky: even-parity mismatch (UART_CAPTURE_PARITY_EN only)
// Modports: master = capture block, slave = line source/consumer.
interface uart_line_capture_if #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 30
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                       uart_rx;
    logic                       line_ack;
    logic                       byte_valid;
    logic [DATA_BITS-1:0]       byte_data;
    logic [DEPTH*DATA_BITS-1:0] line;
    logic [CW-1:0]              line_count;
    logic                       line_valid;
    logic                       line_trunc;
    logic                       frame_err;
    logic                       overrun;
`ifdef UART_CAPTURE_PARITY_EN
    logic                       parity_err;

    modport master (
        input  uart_rx, line_ack,
        output byte_valid, byte_data, line, line_count,
        output line_valid, line_trunc, frame_err, overrun,
        output parity_err
    );

    modport slave (
        output uart_rx, line_ack,
        input  byte_valid, byte_data, line, line_count,
        input  line_valid, line_trunc, frame_err, overrun,
        input  parity_err
    );
`else
    modport master (
        input  uart_rx, line_ack,
        output byte_valid, byte_data, line, line_count,
        output line_valid, line_trunc, frame_err, overrun
    );

    modport slave (
        output uart_rx, line_ack,
        input  byte_valid, byte_data, line, line_count,
        input  line_valid, line_trunc, frame_err, overrun
    );
`endif
endinterface

// File: rtl/uart_line_capture.sv
// uart_line_capture: oversampling UART receiver that shifts accepted bytes
// into a DEPTH-byte window and holds the line after an idle gap until acked.
// Ports:
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    uart_line_capture_if.master (serial in, line out, status flags)
// Build option:
//   UART_CAPTURE_PARITY_EN  expect one even-parity bit between data and stop;
//                           adds the PARITY state and the parity_err flag.
module uart_line_capture #(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 30,
    parameter int IDLE_BITS = 20
) (
    input  logic                clk,
    input  logic                reset,
    uart_line_capture_if.master bus
);
    localparam int DIV      = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int IDLE_CYC = IDLE_BITS * DIV;
    localparam int TW       = $clog2(DIV);
    localparam int IW       = $clog2(IDLE_CYC);
    localparam int BW       = $clog2(DATA_BITS + 1);
    localparam int CW       = $clog2(DEPTH + 1);
    localparam int LW       = DEPTH * DATA_BITS;

    localparam logic [TW-1:0] T_HALF = TW'(DIV / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(DIV - 1);
    localparam logic [IW-1:0] I_END  = IW'(IDLE_CYC - 1);
    localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);
    localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_CAPTURE_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               r_state;
    logic                 r_sync1;
    logic                 r_sync2;
    logic                 r_rx_prev;
    logic [TW-1:0]        r_timer;
    logic [BW-1:0]        r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic [IW-1:0]        r_idle_cnt;
    logic                 r_byte_valid;
    logic [DATA_BITS-1:0] r_byte_data;
    logic [LW-1:0]        r_line;
    logic [CW-1:0]        r_count;
    logic                 r_line_valid;
    logic                 r_trunc;
    logic                 r_frame_err;
    logic                 r_overrun;
`ifdef UART_CAPTURE_PARITY_EN
    logic                 r_par_bad;
    logic                 r_parity_err;
`endif

    logic w_rx;
    logic w_fall;
    logic w_half;
    logic w_full;
    logic w_ack;
    logic w_par_ok;
    logic w_idle_run;

    assign w_rx   = r_sync2;
    // r_rx_prev only goes high once the line has really returned high, so a
    // line still held low after a bad stop bit never looks like a new start.
    assign w_fall = r_rx_prev & ~w_rx;
    assign w_half = (r_timer == T_HALF);
    assign w_full = (r_timer == T_FULL);
    assign w_ack  = r_line_valid & bus.line_ack;

`ifdef UART_CAPTURE_PARITY_EN
    assign w_par_ok = ~r_par_bad;
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_idle_run = (r_state == S_IDLE) && !w_fall &&
                        (r_count != '0) && !r_line_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_idle_cnt   <= '0;
            r_byte_valid <= 1'b0;
            r_byte_data  <= '0;
            r_line       <= '0;
            r_count      <= '0;
            r_line_valid <= 1'b0;
            r_trunc      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
`ifdef UART_CAPTURE_PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_sync1      <= bus.uart_rx;
            r_sync2      <= r_sync1;
            r_rx_prev    <= w_rx;
            r_byte_valid <= 1'b0;

            unique case (r_state)
                S_IDLE: begin
                    r_timer <= '0;
                    if (w_fall) begin
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    r_timer <= r_timer + TW'(1);
                    if (w_half) begin
                        // Re-check mid start bit; high means a glitch.
                        r_timer   <= '0;
                        r_bit_idx <= '0;
                        r_state   <= w_rx ? S_IDLE : S_DATA;
`ifdef UART_CAPTURE_PARITY_EN
                        r_par_bad <= 1'b0;
`endif
                    end
                end

                S_DATA: begin
                    r_timer <= r_timer + TW'(1);
                    if (w_full) begin
                        r_timer   <= '0;
                        r_shift   <= {w_rx, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= r_bit_idx + BW'(1);
                        if (r_bit_idx == B_LAST) begin
`ifdef UART_CAPTURE_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end
                end

`ifdef UART_CAPTURE_PARITY_EN
                S_PARITY: begin
                    r_timer <= r_timer + TW'(1);
                    if (w_full) begin
                        r_timer <= '0;
                        r_state <= S_STOP;
                        if (w_rx != ^r_shift) begin
                            r_par_bad    <= 1'b1;
                            r_parity_err <= 1'b1;
                        end
                    end
                end
`endif

                S_STOP: begin
                    r_timer <= r_timer + TW'(1);
                    if (w_full) begin
                        r_timer <= '0;
                        r_state <= S_IDLE;
                        if (!w_rx) begin
                            r_frame_err <= 1'b1;
                        end else if (w_par_ok) begin
                            r_byte_valid <= 1'b1;
                            r_byte_data  <= r_shift;
                            if (r_line_valid) begin
                                r_overrun <= 1'b1;
                            end else begin
                                r_line <= {r_line[LW-DATA_BITS-1:0], r_shift};
                                if (r_count == C_FULL) begin
                                    r_trunc <= 1'b1;
                                end else begin
                                    r_count <= r_count + CW'(1);
                                end
                            end
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Idle gap timer; any departure from IDLE restarts it.
            if (w_idle_run) begin
                if (r_idle_cnt == I_END) begin
                    r_line_valid <= 1'b1;
                    r_idle_cnt   <= '0;
                end else begin
                    r_idle_cnt <= r_idle_cnt + IW'(1);
                end
            end else begin
                r_idle_cnt <= '0;
            end

            // Placed last so an ack beats a same-cycle accept.
            if (w_ack) begin
                r_line_valid <= 1'b0;
                r_count      <= '0;
                r_trunc      <= 1'b0;
                r_line       <= '0;
            end
        end
    end

    assign bus.byte_valid = r_byte_valid;
    assign bus.byte_data  = r_byte_data;
    assign bus.line       = r_line;
    assign bus.line_count = r_count;
    assign bus.line_valid = r_line_valid;
    assign bus.line_trunc = r_trunc;
    assign bus.frame_err  = r_frame_err;
    assign bus.overrun    = r_overrun;
`ifdef UART_CAPTURE_PARITY_EN
    assign bus.parity_err = r_parity_err;
`endif

endmodule
